// File: rtl/adder_arbiter_seq.sv
// Round-robin arbiter sharing one 4-bit ripple adder for nibble-serial WIDTH-bit adds.
// Optional ADDSEQ_SATURATE_EN: clamp res_sum to all ones when the final carry is set.
`timescale 1ns/1ps

module adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       cout
);
   logic [4:0] c;

   always_comb begin
      c    = '0;
      sum  = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < 4; i++) begin
         sum[i]   = a[i] ^ b[i] ^ c[i];
         c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
      cout = c[4];
   end
endmodule

module adder_arbiter_seq #(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned NUM_REQ = 2,
   localparam int unsigned ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                       clk,
   input  logic                       n_rst,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ*WIDTH-1:0]   req_a,
   input  logic [NUM_REQ*WIDTH-1:0]   req_b,
   input  logic [NUM_REQ-1:0]         req_cin,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic                       res_valid,
   input  logic                       res_ready,
   output logic [WIDTH-1:0]           res_sum,
   output logic                       res_overflow,
   output logic [ID_W-1:0]            res_id,
   output logic                       busy
);
   localparam int unsigned NIB   = WIDTH / 4;
   localparam int unsigned NIB_W = (NIB > 1) ? $clog2(NIB) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state_q, state_d;
   logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]    id_q, id_d;
   logic [WIDTH-1:0]   a_q, a_d, b_q, b_d, sum_q, sum_d;
   logic               carry_q, carry_d, ovf_q, ovf_d;
   logic [NIB_W-1:0]   nib_q, nib_d;

   logic [NUM_REQ-1:0] grant;
   logic               gnt_any;
   logic [ID_W-1:0]    gnt_id;
   logic [WIDTH-1:0]   sel_a, sel_b;
   logic               sel_cin;
   logic [3:0]         add_a, add_b, add_sum;
   logic               add_cout;

   // Two passes: indices at/above rr_ptr first, then the wrapped-around ones below it.
   always_comb begin
      grant   = '0;
      gnt_any = 1'b0;
      gnt_id  = '0;
      sel_a   = '0;
      sel_b   = '0;
      sel_cin = 1'b0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any && req_valid[i] && (i >= 32'(rr_ptr_q))) begin
            gnt_any  = 1'b1;
            gnt_id   = ID_W'(i);
            grant[i] = 1'b1;
            sel_a    = req_a[i*WIDTH +: WIDTH];
            sel_b    = req_b[i*WIDTH +: WIDTH];
            sel_cin  = req_cin[i];
         end
      end
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (!gnt_any && req_valid[i] && (i < 32'(rr_ptr_q))) begin
            gnt_any  = 1'b1;
            gnt_id   = ID_W'(i);
            grant[i] = 1'b1;
            sel_a    = req_a[i*WIDTH +: WIDTH];
            sel_b    = req_b[i*WIDTH +: WIDTH];
            sel_cin  = req_cin[i];
         end
      end
   end

   always_comb begin
      add_a = '0;
      add_b = '0;
      for (int unsigned j = 0; j < NIB; j++) begin
         if (nib_q == NIB_W'(j)) begin
            add_a = a_q[4*j +: 4];
            add_b = b_q[4*j +: 4];
         end
      end
   end

   adder_4bit u_adder (
      .a    (add_a),
      .b    (add_b),
      .cin  (carry_q),
      .sum  (add_sum),
      .cout (add_cout)
   );

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      id_d     = id_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      carry_d  = carry_q;
      ovf_d    = ovf_q;
      nib_d    = nib_q;
      unique case (state_q)
         IDLE: begin
            if (gnt_any) begin
               a_d     = sel_a;
               b_d     = sel_b;
               carry_d = sel_cin;
               id_d    = gnt_id;
               nib_d   = '0;
               state_d = RUN;
               if (32'(gnt_id) + 32'd1 >= NUM_REQ) rr_ptr_d = '0;
               else                                rr_ptr_d = ID_W'(32'(gnt_id) + 32'd1);
            end
         end
         RUN: begin
            for (int unsigned j = 0; j < NIB; j++) begin
               if (nib_q == NIB_W'(j)) sum_d[4*j +: 4] = add_sum;
            end
            carry_d = add_cout;
            nib_d   = nib_q + NIB_W'(1);
            if (nib_q == NIB_W'(NIB - 1)) begin
               ovf_d   = add_cout;
               nib_d   = '0;
               state_d = DONE;
`ifdef ADDSEQ_SATURATE_EN
               if (add_cout) sum_d = '1;
`endif
            end
         end
         DONE: begin
            if (res_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         id_q     <= '0;
         a_q      <= '0;
         b_q      <= '0;
         sum_q    <= '0;
         carry_q  <= 1'b0;
         ovf_q    <= 1'b0;
         nib_q    <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         id_q     <= id_d;
         a_q      <= a_d;
         b_q      <= b_d;
         sum_q    <= sum_d;
         carry_q  <= carry_d;
         ovf_q    <= ovf_d;
         nib_q    <= nib_d;
      end
   end

   // Gated by n_rst so no accept strobe is shown while reset is held.
   assign req_ready    = grant & {NUM_REQ{(state_q == IDLE) && n_rst}};
   assign res_valid    = (state_q == DONE);
   assign busy         = (state_q != IDLE);
   assign res_sum      = sum_q;
   assign res_overflow = ovf_q;
   assign res_id       = id_q;
endmodule

// File: tb/tb_adder_arbiter_seq.sv
// Scoreboard bench for adder_arbiter_seq (WIDTH=8, NUM_REQ=2), directed vectors.
`timescale 1ns/1ps

module tb_adder_arbiter_seq;
   localparam int unsigned WIDTH   = 8;
   localparam int unsigned NUM_REQ = 2;
`ifdef ADDSEQ_SATURATE_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   logic                     clk = 1'b0;
   logic                     n_rst;
   logic [NUM_REQ-1:0]       req_valid;
   logic [NUM_REQ*WIDTH-1:0] req_a, req_b;
   logic [NUM_REQ-1:0]       req_cin;
   logic [NUM_REQ-1:0]       req_ready;
   logic                     res_valid, res_ready;
   logic [WIDTH-1:0]         res_sum;
   logic                     res_overflow;
   logic [0:0]               res_id;
   logic                     busy;

   adder_arbiter_seq #(.WIDTH(WIDTH), .NUM_REQ(NUM_REQ)) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .req_valid    (req_valid),
      .req_a        (req_a),
      .req_b        (req_b),
      .req_cin      (req_cin),
      .req_ready    (req_ready),
      .res_valid    (res_valid),
      .res_ready    (res_ready),
      .res_sum      (res_sum),
      .res_overflow (res_overflow),
      .res_id       (res_id),
      .busy         (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] sum;
      logic       ovf;
      logic [0:0] id;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic push_exp(input logic [7:0] raw_sum, input logic ovf, input logic [0:0] id);
      exp_t e;
      e.sum = (ovf && SAT) ? 8'hFF : raw_sum;
      e.ovf = ovf;
      e.id  = id;
      sb.push_back(e);
   endtask

   // Monitor: a handshake completes on the next rising edge whenever valid & ready here.
   always @(negedge clk) begin
      exp_t m;
      if (n_rst && res_valid && res_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_result actual=%0h required=none", res_sum);
         end else begin
            m = sb.pop_front();
            chk("res_sum", 32'(res_sum), 32'(m.sum));
            chk("res_overflow", 32'(res_overflow), 32'(m.ovf));
            chk("res_id", 32'(res_id), 32'(m.id));
         end
      end
   end

   task automatic wait_grant(input string name, input logic [1:0] req);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (req_ready == '0 && n < 20);
      chk(name, 32'(req_ready), 32'(req));
   endtask

   task automatic run_op(input int id, input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic [7:0] raw_sum, input logic ovf);
      int n = 0;
      @(posedge clk); #1;
      req_a[id*8 +: 8] = a;
      req_b[id*8 +: 8] = b;
      req_cin[id]      = cin;
      req_valid        = 2'(1 << id);
      res_ready        = 1'b1;
      wait_grant("op_grant", 2'(1 << id));
      push_exp(raw_sum, ovf, 1'(id));
      @(posedge clk); #1;
      req_valid        = '0;
      req_a[id*8 +: 8] = 8'hA5;
      req_b[id*8 +: 8] = 8'h5A;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < 20);
      chk("op_done", 32'(busy), 32'd0);
   endtask

   logic [7:0] va [4] = '{8'h3C, 8'hFF, 8'hFF, 8'h9A};
   logic [7:0] vb [4] = '{8'h05, 8'h01, 8'hFF, 8'h26};
   logic       vc [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
   logic [7:0] vs [4] = '{8'h41, 8'h00, 8'hFF, 8'hC1};
   logic       vo [4] = '{1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      int n;
      n_rst     = 1'b0;
      req_valid = 2'b11;
      req_a     = {va[1], va[0]};
      req_b     = {vb[1], vb[0]};
      req_cin   = {vc[1], vc[0]};
      res_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd0);
      chk("rst_res_valid", 32'(res_valid), 32'd0);
      chk("rst_res_sum", 32'(res_sum), 32'd0);
      chk("rst_res_ovf", 32'(res_overflow), 32'd0);
      chk("rst_res_id", 32'(res_id), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);

      @(posedge clk); #1;
      n_rst     = 1'b1;
      res_ready = 1'b1;

      // Both requesters held valid: grants must alternate 0,1,0,1.
      for (int k = 0; k < 4; k++) begin
         int r;
         r = k % 2;
         wait_grant("fair_grant", 2'(1 << r));
         push_exp(vs[k], vo[k], 1'(r));
         @(posedge clk); #1;
         if (k + 2 < 4) begin
            req_a[r*8 +: 8] = va[k+2];
            req_b[r*8 +: 8] = vb[k+2];
            req_cin[r]      = vc[k+2];
         end else begin
            req_a[r*8 +: 8] = 8'h55;
            req_b[r*8 +: 8] = 8'h55;
         end
         if (k == 3) req_valid = '0;
         @(negedge clk);
         chk("ready_in_run", 32'(req_ready), 32'd0);
         chk("busy_in_run", 32'(busy), 32'd1);
         chk("lat_cycle1", 32'(res_valid), 32'd0);
         @(negedge clk);
         chk("lat_cycle2", 32'(res_valid), 32'd0);
         @(negedge clk);
         chk("lat_valid_rise", 32'(res_valid), 32'd1);
      end

      // Backpressure: hold res_ready low in DONE with req0 still requesting.
      @(posedge clk); #1;
      res_ready      = 1'b0;
      req_a[7:0]     = 8'h12;
      req_b[7:0]     = 8'h34;
      req_cin[0]     = 1'b0;
      req_valid      = 2'b01;
      wait_grant("bp_grant", 2'b01);
      push_exp(8'h46, 1'b0, 1'b0);
      @(posedge clk); #1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!res_valid && n < 20);
      chk("bp_valid_rise", 32'(res_valid), 32'd1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_valid_hold", 32'(res_valid), 32'd1);
         chk("bp_sum_hold", 32'(res_sum), 32'h46);
         chk("bp_ready_low", 32'(req_ready), 32'd0);
      end
      @(posedge clk); #1;
      res_ready = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      req_valid = '0;
      @(negedge clk);
      chk("bp_complete_busy", 32'(busy), 32'd0);
      chk("bp_complete_valid", 32'(res_valid), 32'd0);

      // Reset during RUN abandons the op and clears rr_ptr (it was 1 after granting req0).
      @(posedge clk); #1;
      req_a[7:0] = 8'h77;
      req_b[7:0] = 8'h11;
      req_valid  = 2'b01;
      wait_grant("mid_grant", 2'b01);
      @(posedge clk); #1;
      req_valid = '0;
      chk("mid_busy_pre", 32'(busy), 32'd1);
      #2;
      n_rst = 1'b0;
      #1;
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_valid", 32'(res_valid), 32'd0);
      chk("mid_rst_sum", 32'(res_sum), 32'd0);
      chk("mid_rst_ovf", 32'(res_overflow), 32'd0);
      chk("mid_rst_id", 32'(res_id), 32'd0);
      @(posedge clk); #1;
      req_valid = 2'b11;
      n_rst     = 1'b1;
      #2;
      chk("mid_rr_reset", 32'(req_ready), 32'd1);
      req_valid = 2'b00;
      run_op(1, 8'h10, 8'h20, 1'b1, 8'h31, 1'b0);

      n = 0;
      while (sb.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule
